// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared sizes and FSM state type for the 8-way bus arbiter.
//   NREQ  - number of requesters sharing the data bus
//   SEL_W - width of the mux select / owner index
//   BC_W  - width of the per-grant beat counter
package bus_arbiter_pkg;

  localparam int unsigned NREQ  = 8;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned BC_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// bus_arbiter_rr_pick: combinational round-robin winner selection.
//   REQ   [NREQ-1:0]  request vector
//   PTR   [SEL_W-1:0] highest-priority index for this round
//   VALID             at least one request present
//   IDX   [SEL_W-1:0] first requesting index scanning PTR, PTR+1, ... mod NREQ
module bus_arbiter_rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  REQ,
  input  logic [SEL_W-1:0] PTR,
  output logic             VALID,
  output logic [SEL_W-1:0] IDX
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [SEL_W-1:0]  off;

  // Rotate so PTR lands at bit 0, find the lowest set bit, then rotate the
  // offset back; the SEL_W-bit add wraps mod NREQ.
  always_comb begin
    dbl   = {REQ, REQ};
    rot   = dbl[PTR +: NREQ];
    off   = '0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      if (rot[k-1]) off = SEL_W'(k - 1);
    end
    VALID = |rot;
    IDX   = PTR + off;
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin owner selection for the shared 32-bit data bus.
// Grants one requester at a time, holds the grant across a multi-beat
// transfer, and inserts one dead turnaround cycle between owners.
//   CLK      clock, all state on rising edge
//   RST      synchronous active-high reset
//   REQ      [7:0] per-requester bus request, held for the whole transfer
//   LAST     current owner's final beat (sampled only while granted)
//   GNT      [7:0] one-hot grant, zero when no owner
//   SEL      [2:0] current / most recent owner, drives the bus mux select
//   BUSY     grant active (== |GNT)
//   TIMEOUT  one-cycle pulse when a grant ends purely on the beat limit
// MAX_BEATS (1..255) bounds the number of GRANT cycles per owner.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 16
)
(
  input  logic             CLK,
  input  logic             RST,
  input  logic [NREQ-1:0]  REQ,
  input  logic             LAST,
  output logic [NREQ-1:0]  GNT,
  output logic [SEL_W-1:0] SEL,
  output logic             BUSY,
  output logic             TIMEOUT
);

  localparam logic [BC_W-1:0] BC_LIMIT = BC_W'(MAX_BEATS - 1);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [BC_W-1:0]  bc;

  logic             pick_valid;
  logic [SEL_W-1:0] pick_idx;
  logic             limit_hit;
  logic             req_drop;
  logic             grant_end;

  bus_arbiter_rr_pick u_rr_pick (
    .REQ   (REQ),
    .PTR   (ptr),
    .VALID (pick_valid),
    .IDX   (pick_idx)
  );

  always_comb begin
    limit_hit = (bc == BC_LIMIT);
    req_drop  = !REQ[SEL];
    grant_end = LAST || req_drop || limit_hit;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      GNT     <= '0;
      SEL     <= '0;
      BUSY    <= 1'b0;
      TIMEOUT <= 1'b0;
      ptr     <= '0;
      bc      <= '0;
    end else begin
      TIMEOUT <= 1'b0;
      case (state)
        ST_IDLE, ST_TURN: begin
          if (pick_valid) begin
            state <= ST_GRANT;
            GNT   <= NREQ'(1) << pick_idx;
            SEL   <= pick_idx;
            BUSY  <= 1'b1;
            bc    <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (grant_end) begin
            // SEL is left on the old owner so the mux output stays stable
            // through the turnaround cycle.
            state   <= ST_TURN;
            GNT     <= '0;
            BUSY    <= 1'b0;
            ptr     <= SEL + SEL_W'(1);
            TIMEOUT <= limit_hit && !LAST && !req_drop;
          end else begin
            bc <= bc + BC_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          GNT   <= '0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int unsigned MB = 4;

  logic       CLK;
  logic       RST;
  logic [7:0] REQ;
  logic       LAST;
  logic [7:0] GNT;
  logic [2:0] SEL;
  logic       BUSY;
  logic       TIMEOUT;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.MAX_BEATS(MB)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .REQ     (REQ),
    .LAST    (LAST),
    .GNT     (GNT),
    .SEL     (SEL),
    .BUSY    (BUSY),
    .TIMEOUT (TIMEOUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: owner index (-1 = none), beats already served,
  // next-priority pointer, last owner and timeout flag.
  int         m_owner = -1;
  int         m_beats = 0;
  int         m_ptr   = 0;
  logic [2:0] m_sel   = 3'd0;
  logic       m_to    = 1'b0;
  logic [7:0] m_gnt;

  assign m_gnt = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;

  always @(posedge CLK) begin : model
    int o, b, p;
    logic [2:0] s;
    logic t;
    o = m_owner; b = m_beats; p = m_ptr; s = m_sel; t = 1'b0;
    if (RST) begin
      o = -1; b = 0; p = 0; s = 3'd0;
    end else if (o >= 0) begin
      b = b + 1;
      if (LAST || !REQ[o] || b == int'(MB)) begin
        t = (b == int'(MB)) && !LAST && REQ[o];
        p = (o + 1) % 8;
        o = -1;
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (o < 0 && REQ[(p + k) % 8]) begin
          o = (p + k) % 8;
          b = 0;
          s = 3'(o);
        end
      end
    end
    m_owner <= o; m_beats <= b; m_ptr <= p; m_sel <= s; m_to <= t;
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1; REQ = 8'h00; LAST = 1'b0;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; REQ = 8'hFF; LAST = 1'b0;
    tick(); tick();
    checks++;
    if ({GNT, SEL, BUSY, TIMEOUT} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state got gnt=%h sel=%0d busy=%b to=%b want all zero", GNT, SEL, BUSY, TIMEOUT);
    end
    RST = 1'b0; REQ = 8'h00;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    REQ = 8'h20;
    tick();
    checks++;
    if ({GNT, SEL, BUSY} !== {8'h20, 3'd5, 1'b1}) begin
      errors++;
      $display("FAIL single_grant got gnt=%h sel=%0d busy=%b want 20/5/1", GNT, SEL, BUSY);
    end
    tick(); tick();
    LAST = 1'b1;
    tick();
    checks++;
    if ({GNT, SEL, BUSY, TIMEOUT} !== {8'h00, 3'd5, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_release got gnt=%h sel=%0d busy=%b to=%b want 00/5/0/0", GNT, SEL, BUSY, TIMEOUT);
    end
    LAST = 1'b0; REQ = 8'h00;
    tick();
    checks++;
    if ({GNT, SEL} !== {8'h00, 3'd5}) begin
      errors++;
      $display("FAIL single_sel_hold got gnt=%h sel=%0d want 00/5", GNT, SEL);
    end
  endtask

  task automatic test_rotation();
    logic [7:0] want;
    do_reset();
    REQ = 8'hFF; LAST = 1'b1;
    for (int g = 0; g < 9; g++) begin
      tick();
      want = 8'd1 << (g % 8);
      checks++;
      if ({GNT, SEL} !== {want, 3'(g % 8)}) begin
        errors++;
        $display("FAIL rotation_grant%0d got gnt=%h sel=%0d want %h/%0d", g, GNT, SEL, want, g % 8);
      end
      tick();
      checks++;
      if (GNT !== 8'h00) begin
        errors++;
        $display("FAIL rotation_gap%0d got gnt=%h want 00", g, GNT);
      end
    end
    REQ = 8'h00; LAST = 1'b0;
    tick();
  endtask

  task automatic test_wrap_skip();
    do_reset();
    REQ = 8'h20; LAST = 1'b1;
    tick();
    tick();
    REQ = 8'h03;
    tick();
    checks++;
    if ({GNT, SEL} !== {8'h01, 3'd0}) begin
      errors++;
      $display("FAIL wrap_winner got gnt=%h sel=%0d want 01/0", GNT, SEL);
    end
    tick(); tick();
    checks++;
    if ({GNT, SEL} !== {8'h02, 3'd1}) begin
      errors++;
      $display("FAIL skip_winner got gnt=%h sel=%0d want 02/1", GNT, SEL);
    end
    REQ = 8'h00; LAST = 1'b0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    do_reset();
    REQ = 8'h04; LAST = 1'b0;
    tick();
    for (int i = 0; i < int'(MB); i++) begin
      checks++;
      if ({GNT, TIMEOUT} !== {8'h04, 1'b0}) begin
        errors++;
        $display("FAIL timeout_beat%0d got gnt=%h to=%b want 04/0", i, GNT, TIMEOUT);
      end
      tick();
    end
    checks++;
    if ({GNT, BUSY, TIMEOUT} !== {8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL timeout_release got gnt=%h busy=%b to=%b want 00/0/1", GNT, BUSY, TIMEOUT);
    end
    tick();
    checks++;
    if ({GNT, TIMEOUT} !== {8'h04, 1'b0}) begin
      errors++;
      $display("FAIL timeout_pulse_width got gnt=%h to=%b want 04/0", GNT, TIMEOUT);
    end
    tick(); tick(); tick();
    LAST = 1'b1;
    tick();
    checks++;
    if ({GNT, TIMEOUT} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL timeout_last_coincide got gnt=%h to=%b want 00/0", GNT, TIMEOUT);
    end
    REQ = 8'h00; LAST = 1'b0;
    tick();
  endtask

  task automatic test_drop();
    do_reset();
    REQ = 8'h04;
    tick();
    REQ = 8'h44;
    tick();
    REQ = 8'h40;
    tick();
    checks++;
    if ({GNT, SEL, BUSY, TIMEOUT} !== {8'h00, 3'd2, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL drop_turn got gnt=%h sel=%0d busy=%b to=%b want 00/2/0/0", GNT, SEL, BUSY, TIMEOUT);
    end
    tick();
    checks++;
    if ({GNT, SEL, BUSY} !== {8'h40, 3'd6, 1'b1}) begin
      errors++;
      $display("FAIL drop_next_owner got gnt=%h sel=%0d busy=%b want 40/6/1", GNT, SEL, BUSY);
    end
    LAST = 1'b1;
    tick();
    REQ = 8'h00; LAST = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    REQ = 8'h40; LAST = 1'b1;
    tick(); tick();
    REQ = 8'h08; LAST = 1'b0;
    tick(); tick();
    checks++;
    if ({GNT, SEL} !== {8'h08, 3'd3}) begin
      errors++;
      $display("FAIL midreset_owner got gnt=%h sel=%0d want 08/3", GNT, SEL);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if ({GNT, SEL, BUSY, TIMEOUT} !== 13'd0) begin
      errors++;
      $display("FAIL midreset_clear got gnt=%h sel=%0d busy=%b to=%b want all zero", GNT, SEL, BUSY, TIMEOUT);
    end
    REQ = 8'h09;
    tick();
    checks++;
    if ({GNT, SEL} !== {8'h01, 3'd0}) begin
      errors++;
      $display("FAIL midreset_ptr got gnt=%h sel=%0d want 01/0", GNT, SEL);
    end
    REQ = 8'h08; LAST = 1'b1;
    tick(); LAST = 1'b0;
    tick();
    checks++;
    if ({GNT, SEL} !== {8'h08, 3'd3}) begin
      errors++;
      $display("FAIL midreset_regrant got gnt=%h sel=%0d want 08/3", GNT, SEL);
    end
    REQ = 8'h00;
    tick(); tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      checks++;
      if ({GNT, SEL, BUSY, TIMEOUT} !== {m_gnt, m_sel, (m_owner >= 0), m_to}) begin
        errors++;
        $display("FAIL random_model cyc%0d got gnt=%h sel=%0d busy=%b to=%b want %h/%0d/%b/%b",
                 n, GNT, SEL, BUSY, TIMEOUT, m_gnt, m_sel, (m_owner >= 0), m_to);
      end
      checks++;
      if (!$onehot0(GNT) || (BUSY !== (GNT != 8'h00)) || (BUSY && !GNT[SEL])) begin
        errors++;
        $display("FAIL random_invariant cyc%0d got gnt=%h sel=%0d busy=%b want onehot0, busy==|gnt, gnt[sel]",
                 n, GNT, SEL, BUSY);
      end
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 6) == 0) REQ[b] = ~REQ[b];
      LAST = ($urandom_range(0, 4) == 0);
      RST  = ($urandom_range(0, 199) == 0);
      @(posedge CLK);
      @(negedge CLK);
    end
    RST = 1'b0; REQ = 8'h00; LAST = 1'b0;
    tick();
  endtask

  initial begin
    RST = 1'b1; REQ = 8'h00; LAST = 1'b0;
    @(negedge CLK);
    test_reset();
    test_single();
    test_rotation();
    test_wrap_skip();
    test_timeout();
    test_drop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter sitting directly upstream of the 8-channel 32-bit bus multiplexer.
- Grants one of eight requesters ownership of the shared DATABUS and drives the mux SEL[2:0] with the owner's index.
- Holds the grant for a multi-beat transfer, reclaims it on LAST, request drop or beat timeout, and inserts one turnaround cycle between owners.

Parameters:
MAX_BEATS, 16, maximum beats per grant before forced release; legal range 1..255.

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  synchronous, active-high reset
REQ  input  8  REQ[i]=1: requester i wants the bus; held high for the whole transfer
LAST  input  1  current owner's final beat; sampled only in GRANT
GNT  output  8  one-hot grant, all zero when no owner
SEL  output  3  index of current/most recent owner; connects to the mux SEL
BUSY  output  1  1 while a grant is active (equals |GNT)
TIMEOUT  output  1  one-cycle pulse when a grant is ended by the beat limit

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high.
- All outputs are registered.
- Reset (RST=1 at an edge), also when asserted mid-grant:
  - state IDLE, GNT=0, SEL=0, BUSY=0, TIMEOUT=0, priority pointer PTR=0, beat counter BC=0.
  - Outputs take these values after that edge.
- States: IDLE, GRANT, TURN (2-bit encoding 0, 1, 2; code 3 is illegal and recovers to IDLE at the next edge).
- Arbitration, done in IDLE and TURN:
  - Winner is the first i with REQ[i]=1, scanning PTR, PTR+1, ... mod 8.
  - If there is a winner: next edge GNT=1<<i, SEL=i, BUSY=1, BC=0, state GRANT.
  - With no request, stay IDLE (TURN goes to IDLE); SEL holds its value.
- Latency: REQ rising before edge N in IDLE gives GNT visible after edge N (1 cycle).
- GRANT (owner o=SEL):
  - Each cycle BC increments.
  - End condition, evaluated at each edge: LAST=1, or REQ[o]=0, or BC==MAX_BEATS-1.
  - On end: GNT=0, BUSY=0, PTR=(o+1) mod 8 with wrap 7->0, state TURN. SEL keeps o through TURN so the mux output stays stable.
  - TIMEOUT=1 for one cycle only when the end is caused solely by the beat limit. If LAST or a REQ drop coincides with the limit, TIMEOUT=0.
  - Non-owner REQ bits are ignored while in GRANT.
- Beat count: an owner receives at most MAX_BEATS GRANT cycles. MAX_BEATS=1 gives single-beat grants.
- TURN is exactly one dead cycle. Back-to-back owners therefore see GNT low for exactly one cycle.
- Fairness: a requester continuously asserting REQ is granted within 7 foreign grants.
- Invariants:
  - GNT is always zero or one-hot.
  - BUSY==(GNT!=0).
  - When BUSY=1, GNT[SEL]=1.
- Counter width is 8 bits and never wraps, because the end condition fires at MAX_BEATS-1.

Decomposition:
- Shared package holds:
  - NREQ=8, SEL_W=3, BC_W=8
  - state encodings ST_IDLE=0, ST_GRANT=1, ST_TURN=2
- One combinational sub-module, rr_pick:
  - inputs: REQ[7:0], PTR[2:0]
  - outputs: VALID, IDX[2:0]
  - implementation: rotate REQ by PTR, priority-encode, add PTR mod 8.
- The FSM, counter and output registers live in bus_arbiter.

Test Plan:
- Reset mid-grant: owner 3 in GRANT, RST=1 for one edge -> after edge GNT=0, SEL=0, BUSY=0, TIMEOUT=0; REQ=8'h08 after release -> GNT=8'h08 one cycle later (PTR back to 0).
- Single request: REQ=8'h20 from IDLE -> after 1 edge GNT=8'h20, SEL=5, BUSY=1; LAST=1 on 3rd GRANT cycle -> next edge GNT=0, BUSY=0, SEL stays 5.
- Round-robin rotation: REQ=8'hFF held, each owner asserts LAST on its first beat -> grant order 0,1,2,...,7,0; exactly one GNT-low cycle between grants.
- Wrap and skip: PTR=6 (previous owner 5), REQ=8'h03 -> winner 0, not 1; then PTR=1 -> winner 1.
- Timeout: MAX_BEATS=4, REQ=8'h04 held, LAST=0 -> GNT=8'h04 for exactly 4 cycles, TIMEOUT=1 on the release edge only; same run with LAST=1 on beat 4 -> TIMEOUT stays 0.
- Request drop: owner 2, REQ[2] falls on beat 2 while REQ[6]=1 -> release next edge, TURN one cycle, then GNT=8'h40, SEL=6.
